// File: rtl/adder_pkg.sv
// Shared state encoding for the bit-serial adder/subtractor.
package adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } adder_state_e;

endpackage

// File: rtl/FullAdder.sv
// Single-bit full adder cell; the serial adder reuses one copy for every bit.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, LSB first, one bit per clock through a single full adder.
// Result bits shift into the top of the A register as its operand bits shift out.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   RUN   | one operand bit pair consumed per edge, cnt_q = bit index
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int              CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(WIDTH - 1);

  adder_state_e     state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic             c_out_q;
  logic             ovf_q;
  logic             fa_sum;
  logic             fa_cout;

  FullAdder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .c_in (carry_q),
    .sum  (fa_sum),
    .c_out(fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= {fa_sum, a_q[WIDTH-1:1]};
          b_q     <= {1'b0, b_q[WIDTH-1:1]};
          carry_q <= fa_cout;
          if (cnt_q == CNT_TC) begin
            // carry_q is the carry into the MSB at this point.
            sum_q   <= {fa_sum, a_q[WIDTH-1:1]};
            c_out_q <= fa_cout;
            ovf_q   <= carry_q ^ fa_cout;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand and result width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only when idle.
REQ-005 SHALL have port sub  input  1  mode select: 0 = a+b, 1 = a-b; sampled with start.
REQ-006 SHALL have port a  input  WIDTH  first operand; sampled with start.
REQ-007 SHALL have port b  input  WIDTH  second operand; sampled with start.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a new valid result.
REQ-010 SHALL have port sum  output  WIDTH  result, held until the next completion.
REQ-011 SHALL have port c_out  output  1  unsigned carry out; in subtract mode 1 = no borrow.
REQ-012 SHALL have port ovf  output  1  signed two's-complement overflow flag.

Function
REQ-013 SHALL implement FSM states IDLE and RUN only.
REQ-014 In IDLE, start=1 at a clock edge E0: capture a, b, sub; go to RUN; busy=1 from E0.
REQ-015 On capture: b operand = b when sub=0, ~b when sub=1; carry register = sub.
REQ-016 In RUN, process one bit per edge, LSB first: bit i computed on edge E(i+1), i = 0..WIDTH-1.
REQ-017 Bit counter SHALL be clog2(WIDTH)-bit wide; terminal count WIDTH-1; no wrap beyond it.
REQ-018 On edge E(WIDTH): load sum, c_out, ovf; done=1 for exactly one cycle; busy=0; return to IDLE.
REQ-019 Latency: result valid and done high WIDTH edges after the capture edge.
REQ-020 c_out = carry out of the MSB; ovf = carry into MSB XOR carry out of MSB.
REQ-021 sum, c_out, ovf SHALL NOT change except at completion or reset; no partial results visible.
REQ-022 start while busy=1 SHALL be ignored; no queuing, captured operands unaffected.
REQ-023 start high in the done cycle SHALL be accepted at the next edge; throughput = one result per WIDTH+1 cycles.
REQ-024 Input changes on a, b, sub after capture SHALL NOT affect the running operation.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, sum=0, c_out=0, ovf=0, counter and shift registers 0.
REQ-026 Reset during RUN SHALL abort the operation; no done pulse follows release.
REQ-027 First start after rst_n release SHALL be accepted on the first edge where rst_n=1.

Structure
REQ-028 FSM state typedef and state encodings SHALL reside in shared package adder_pkg.
REQ-029 The per-bit sum and carry SHALL come from exactly one instance of the existing FullAdder cell (a, b, c_in, sum, c_out).
REQ-030 Operand and result storage SHALL be shift registers; no WIDTH-wide combinational adder permitted.

Verification
REQ-031 WIDTH=8, add 0x5A+0x33 -> done exactly 8 edges after capture; sum=0x8D, c_out=0, ovf=1.
REQ-032 WIDTH=8, add 0xFF+0x01 -> sum=0x00, c_out=1, ovf=0.
REQ-033 WIDTH=8, sub 0x10-0x20 -> sum=0xF0, c_out=0, ovf=0; sub 0x80-0x01 -> sum=0x7F, c_out=1, ovf=1.
REQ-034 WIDTH=8, start pulsed at cycle 3 of a run with different operands -> ignored; first result unchanged; single done pulse.
REQ-035 WIDTH=8, rst_n low at cycle 4 of a run -> all outputs 0 at once, no done; subsequent add 0x01+0x01 -> sum=0x02 after 8 edges.
REQ-036 WIDTH=2, add 3+1 -> sum=0, c_out=1, ovf=0 after 2 edges; back-to-back start in done cycle -> second result 3 cycles later.
